// File: rtl/lpif_tx_chan_dist_if.sv
// LPIF downstream flit handshake bundle between the
// user side (master) and the transmit distributor (slave).
interface lpif_tx_chan_dist_if #(
  parameter int DATA_BYTES = 64
);
  localparam int BS_W = $clog2(DATA_BYTES);

  logic [3:0]              dstrm_state;
  logic [1:0]              dstrm_protid;
  logic [8*DATA_BYTES-1:0] dstrm_data;
  logic [BS_W-1:0]         dstrm_bstart;
  logic [DATA_BYTES-1:0]   dstrm_bvalid;
  logic                    dstrm_valid;
  logic                    dstrm_ready;

  modport master (
    output dstrm_state,
    output dstrm_protid,
    output dstrm_data,
    output dstrm_bstart,
    output dstrm_bvalid,
    output dstrm_valid,
    input  dstrm_ready
  );

  modport slave (
    input  dstrm_state,
    input  dstrm_protid,
    input  dstrm_data,
    input  dstrm_bstart,
    input  dstrm_bvalid,
    input  dstrm_valid,
    output dstrm_ready
  );
endinterface

// File: rtl/lpif_tx_chan_dist.sv
// LPIF flit buffer and striper onto per-channel AIB PHY
// beats with marker/strobe framing and online delay.
module lpif_tx_chan_dist #(
  parameter int NUM_CHAN   = 16,
  parameter int CHAN_WIDTH = 40,
  parameter int DATA_BYTES = 64,
  parameter int FIFO_DEPTH = 4,
  parameter int STB_PERIOD = 8
) (
  input  logic clk_wr,
  input  logic rst_wr,
  input  logic tx_online,
  input  logic [7:0] delay_xz_value,
  input  logic half_mode,
  lpif_tx_chan_dist_if.slave dstrm,
  output logic [NUM_CHAN*CHAN_WIDTH-1:0] tx_phy,
  output logic tx_online_delay,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level,
  output logic [15:0] flits_sent
);

  localparam int BS_W   = $clog2(DATA_BYTES);
  localparam int FLIT_W = 4 + 2 + 8*DATA_BYTES
                        + BS_W + DATA_BYTES + 1;
  localparam int PLW    = CHAN_WIDTH - 2;
  localparam int PW     = NUM_CHAN * PLW;
  localparam int HPW    = PW / 2;
  localparam int HC     = NUM_CHAN / 2;
  localparam int TW     = NUM_CHAN * CHAN_WIDTH;
  localparam int AW     = $clog2(FIFO_DEPTH);
  localparam int LW     = AW + 1;
  localparam int SW     = (STB_PERIOD > 1)
                        ? $clog2(STB_PERIOD) : 1;

  if (HC * PLW * 2 < FLIT_W) begin : g_bad_width
    $error("lpif_tx_chan_dist: channels too narrow");
  end
  if (NUM_CHAN % 2 != 0) begin : g_bad_chan
    $error("lpif_tx_chan_dist: NUM_CHAN must be even");
  end
  if (FIFO_DEPTH < 2 ||
      (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_fifo
    $error("lpif_tx_chan_dist: bad FIFO_DEPTH");
  end
  if (STB_PERIOD < 1) begin : g_bad_stb
    $error("lpif_tx_chan_dist: bad STB_PERIOD");
  end

  logic              online_q, online_d;
  logic [7:0]        dly_q, dly_d;
  logic              en_q, en_d;
  logic              half_q, half_d;
  logic              beat_q, beat_d;
  logic [SW-1:0]     stb_q, stb_d;
  logic [HPW-1:0]    hold_q, hold_d;
  logic              hvld_q, hvld_d;
  logic [AW-1:0]     wptr_q, wptr_d;
  logic [AW-1:0]     rptr_q, rptr_d;
  logic [LW-1:0]     lvl_q, lvl_d;
  logic [TW-1:0]     phy_q, phy_d;
  logic [15:0]       sent_q, sent_d;
  logic [FLIT_W-1:0] mem_q [FIFO_DEPTH];

  logic [FLIT_W-1:0] flit_in;
  logic [FLIT_W-1:0] head;
  logic [PW-1:0]     head_pad;
  logic [PW-1:0]     slice;
  logic [7:0]        cnt;
  logic              ready;
  logic              push;
  logic              pop;
  logic              rise;
  logic              act;
  logic              nonempty;
  logic              mark;
  logic              stb_hit;
  logic              last_vld;

  always_comb begin
    flit_in = {dstrm.dstrm_state,
               dstrm.dstrm_protid,
               dstrm.dstrm_data,
               dstrm.dstrm_bstart,
               dstrm.dstrm_bvalid,
               dstrm.dstrm_valid};
    ready    = tx_online && (lvl_q < LW'(FIFO_DEPTH));
    push     = dstrm.dstrm_valid && ready;
    nonempty = (lvl_q != '0);
    head     = mem_q[rptr_q];
    head_pad = PW'(head);
    rise     = tx_online && !online_q;
    act      = en_q && tx_online;
    stb_hit  = (stb_q == '0);
  end

  // Delay count reloads on the rising edge; zero enables next cycle.
  always_comb begin
    online_d = tx_online;
    cnt      = rise ? delay_xz_value : dly_q;
    dly_d    = 8'd0;
    en_d     = 1'b0;
    half_d   = half_q;
    if (tx_online) begin
      dly_d = (cnt != 8'd0) ? cnt - 8'd1 : cnt;
      en_d  = en_q || (cnt == 8'd0);
    end
    if (en_d && !en_q) begin
      half_d = half_mode;
    end
  end

  always_comb begin
    pop      = 1'b0;
    slice    = '0;
    mark     = 1'b0;
    last_vld = 1'b0;
    beat_d   = 1'b0;
    stb_d    = '0;
    hold_d   = hold_q;
    hvld_d   = 1'b0;
    sent_d   = sent_q;
    if (act) begin
      stb_d = (stb_q == SW'(STB_PERIOD - 1))
            ? '0 : stb_q + SW'(1);
      unique case (1'b1)
        !half_q: begin
          pop      = nonempty;
          slice    = nonempty ? head_pad : '0;
          mark     = 1'b1;
          last_vld = nonempty && head[0];
        end
        half_q && !beat_q: begin
          pop    = nonempty;
          slice  = nonempty
                 ? PW'(head_pad[HPW-1:0]) : '0;
          hold_d = nonempty
                 ? head_pad[PW-1:HPW] : '0;
          hvld_d = nonempty && head[0];
          beat_d = 1'b1;
        end
        default: begin
          slice    = PW'(hold_q);
          mark     = 1'b1;
          last_vld = hvld_q;
        end
      endcase
      if (last_vld) begin
        sent_d = sent_q + 16'd1;
      end
    end
  end

  always_comb begin
    phy_d = '0;
    if (act) begin
      for (int c = 0; c < NUM_CHAN; c++) begin
        if (!half_q || c < HC) begin
          phy_d[c*CHAN_WIDTH +: CHAN_WIDTH] =
            {mark, slice[c*PLW +: PLW], stb_hit};
        end
      end
    end
  end

  // Going offline flushes the buffer without draining it.
  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    lvl_d  = lvl_q;
    if (!tx_online) begin
      wptr_d = '0;
      rptr_d = '0;
      lvl_d  = '0;
    end else begin
      if (push) begin
        wptr_d = wptr_q + AW'(1);
      end
      if (pop) begin
        rptr_d = rptr_q + AW'(1);
      end
      lvl_d = lvl_q + LW'(push) - LW'(pop);
    end
  end

  always_ff @(posedge clk_wr) begin
    if (push) begin
      mem_q[wptr_q] <= flit_in;
    end
  end

  always_ff @(posedge clk_wr) begin
    if (rst_wr) begin
      online_q <= 1'b0;
      dly_q    <= '0;
      en_q     <= 1'b0;
      half_q   <= 1'b0;
      beat_q   <= 1'b0;
      stb_q    <= '0;
      hold_q   <= '0;
      hvld_q   <= 1'b0;
      wptr_q   <= '0;
      rptr_q   <= '0;
      lvl_q    <= '0;
      phy_q    <= '0;
      sent_q   <= '0;
    end else begin
      online_q <= online_d;
      dly_q    <= dly_d;
      en_q     <= en_d;
      half_q   <= half_d;
      beat_q   <= beat_d;
      stb_q    <= stb_d;
      hold_q   <= hold_d;
      hvld_q   <= hvld_d;
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      lvl_q    <= lvl_d;
      phy_q    <= phy_d;
      sent_q   <= sent_d;
    end
  end

  assign dstrm.dstrm_ready = ready;
  assign tx_phy            = phy_q;
  assign tx_online_delay   = en_q;
  assign fifo_level        = lvl_q;
  assign flits_sent        = sent_q;

endmodule

// File: doc/lpif_tx_chan_dist.md
Name: lpif_tx_chan_dist

Overview:
Parametrised downstream LPIF transmit distributor for the logic-link layer. It accepts LPIF flits (state, protid, data, bstart, bvalid, valid) over a valid/ready handshake and buffers them in a small FIFO. Each flit is striped across NUM_CHAN PHY channels with marker and strobe framing, in either full-width mode (1 beat per flit) or half-width mode (2 beats per flit). It sits between the LPIF user interface and the per-channel AIB PHY buses and includes its own online-delay sequencing.

Parameters:
NUM_CHAN, 16, number of PHY channels; must be even.
CHAN_WIDTH, 40, bits per channel per beat. Bit 0 is the strobe, bit CHAN_WIDTH-1 is the marker, bits [CHAN_WIDTH-2:1] are payload.
DATA_BYTES, 64, LPIF data bytes. BS_W = $clog2(DATA_BYTES). FLIT_W = 4+2+8*DATA_BYTES+BS_W+DATA_BYTES+1 (589 by default).
FIFO_DEPTH, 4, flit buffer entries; power of 2, minimum 2.
STB_PERIOD, 8, strobe repeat interval in beats; minimum 1.

Ports:
clk_wr  in  1  single clock.
rst_wr  in  1  synchronous active-high reset.
tx_online  in  1  link-up request.
delay_xz_value  in  8  cycles from tx_online rise to transmit enable.
half_mode  in  1  0 = all channels, 1 = lower NUM_CHAN/2 channels only.
dstrm_state  in  4  LPIF state.
dstrm_protid  in  2  protocol id.
dstrm_data  in  8*DATA_BYTES  flit data.
dstrm_bstart  in  BS_W  byte start.
dstrm_bvalid  in  DATA_BYTES  byte valids.
dstrm_valid  in  1  flit valid / push request.
dstrm_ready  out  1  flit accept.
tx_phy  out  NUM_CHAN*CHAN_WIDTH  channel c occupies bits [c*CHAN_WIDTH +: CHAN_WIDTH].
tx_online_delay  out  1  transmit enabled.
fifo_level  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy.
flits_sent  out  16  count of non-idle flits transmitted; wraps.

Behaviour:
- Reset: all outputs 0; FIFO empty; every counter 0; half_mode latch 0.
- Flit packing: {state, protid, data, bstart, bvalid, valid}, with state in the MSBs and valid at bit 0. The packed flit is written into the FIFO when dstrm_valid && dstrm_ready.
- dstrm_ready = tx_online && (fifo_level < FIFO_DEPTH). Ready is combinational from registered level, so push is allowed while full only if a pop happens the same cycle? No: push is blocked when full, even with a simultaneous pop.
- Online sequencing:
  - On a rising edge of tx_online, load the delay counter with delay_xz_value.
  - Decrement the counter each cycle while tx_online is high.
  - tx_online_delay asserts the cycle after the counter equals 0. A delay of 0 gives assertion 1 cycle after the rise.
  - tx_online low: the next cycle has tx_online_delay=0, FIFO flushed, beat/strobe counters cleared, tx_phy=0.
  - Any in-flight flit is discarded and is not counted.
- Mode latch: half_mode is sampled on the cycle tx_online_delay rises. Changes to half_mode while online are ignored.
- Beat sequencing while tx_online_delay=1: the payload per beat is PW = NUM_CHAN*(CHAN_WIDTH-2) in full mode and PW/2 in half mode.
  - Full mode: 1 beat per flit. Pop at every beat if the FIFO is non-empty; otherwise send an idle flit (all zero).
  - Half mode: 2 beats per flit. Beat 0 carries flit bits [0 +: PW/2]. Beat 1 carries the remaining bits, zero-padded. The pop/idle decision is made only at beat 0.
  - Marker bit = 1 on every channel on the last beat of each flit (every beat in full mode, beat 1 in half mode), idle flits included; 0 otherwise.
  - Strobe bit = 1 on every active channel when the strobe counter equals 0. The strobe counter counts 0..STB_PERIOD-1 per beat, wraps, and starts at 0 on the first online beat.
  - In half mode, the upper NUM_CHAN/2 channels are driven all-zero, including marker and strobe.
  - Channel c payload = bits [c*(CHAN_WIDTH-2) +: CHAN_WIDTH-2] of the current beat slice.
- Latency: tx_phy is registered.
  - A flit pushed in cycle N into an empty FIFO while online at a beat-0 boundary appears on tx_phy in cycle N+2 (FIFO write N, pop N+1, output register N+2).
- Simultaneous push and pop when not full: level unchanged.
- flits_sent increments on the last beat of any transmitted flit whose valid bit is 1, and wraps from 0xFFFF to 0.
- Design-time check: elaboration error if (NUM_CHAN/2)*(CHAN_WIDTH-2)*2 < FLIT_W.

Test Plan:
- Reset/online: rst_wr=1 for 3 cycles, then tx_online=1 with delay_xz_value=5 -> tx_phy=0 and tx_online_delay=0 until cycle 6 after the rise, then tx_online_delay=1. The first beat has marker=1 and strobe=1 on all 16 channels with an idle payload.
- Full mode stream: 10 back-to-back flits, data=incrementing pattern, valid=1 -> one flit per cycle. Channel 0 bits[38:1] equal flit bits [37:0]. Marker=1 every beat, strobe every 8th beat, flits_sent=10.
- Half mode: half_mode=1 before online, 3 flits -> 6 beats. Channels 8..15 stay 0. Marker=1 on beats 1, 3, 5 only. Beat 1 channel 7 upper payload bits are zero-padded beyond bit 588.
- Backpressure: tx_online high with delay 20, push 6 flits -> 4 accepted, then dstrm_ready=0 and fifo_level=4. After enable, 4 flits drain in order and ready re-asserts.
- Mid-operation drop: tx_online falls while the FIFO holds 3 flits in half mode at beat 0 -> next cycle tx_phy=0, fifo_level=0, flits_sent unchanged. The re-online sequence restarts the delay and the strobe counter.
- flits_sent wrap: preload via 65537 valid flits -> flits_sent=1.
